hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised successor to the pipeline hazard unit. A per-register scoreboard of
//  result-ready countdowns stalls ID until every source is forwardable; this
//  generalises load-use to any producer latency (load, mul, div).
//  Sits beside the ID stage. Drives the PC/IF-ID/flush controls with the same
//  priority scheme: branch > jump > ALU stall > SWM stall > scoreboard stall.
// PARAMETERS
//  REG_AW   5  register address width; NUM_REGS = 2**REG_AW
//  NUM_SRC  2  source operands checked per ID instruction
//  CNT_W    3  countdown width; max producer latency = 2**CNT_W-1
// PORTS
//  clk_i          in   1              clock, rising edge
//  rst_n          in   1              async active-low reset
//  PCSrc          in   1              branch taken, resolved in EX
//  EX_j/EX_jal/EX_jr in 1             jump types in EX
//  ALU_stall      in   1              multi-cycle ALU busy
//  SWM_stall_i    in   1              store-word-memory stall
//  id_src_vld     in   NUM_SRC        per-source "operand is read"
//  id_src_reg     in   NUM_SRC*REG_AW packed source register numbers
//  id_wr_en       in   1              ID instruction writes a register
//  id_wr_reg      in   REG_AW         destination register
//  id_wr_lat      in   CNT_W          cycles after issue until forwardable (0 = ALU)
//  PCWrite        out  1              PC update enable
//  IF_ID_remain   out  1              hold IF/ID register
//  IF_Flush/ID_Flush/EX_Flush out 1   stage flushes
//  sb_busy        out  1              any scoreboard entry nonzero
// BEHAVIOUR
//  - State: cnt[r] (CNT_W) per register; ex_vld, ex_reg (last issued writer).
//  - Reset (async, rst_n=0): all cnt=0, ex_vld=0. Outputs with idle inputs:
//    PCWrite=1, others 0, sb_busy=0.
//  - advance = !ALU_stall && !SWM_stall_i. Counters change only on advance cycles.
//  - sb_hit = OR over s of id_src_vld[s] && src!=0 && cnt[src]!=0.
//  - Control outputs are combinational, first match wins:
//    PCSrc: PCW=1 IF/ID/EX_Flush=1 remain=0
//    EX_jr|EX_j|EX_jal: PCW=1 IF/ID_Flush=1 EX_Flush=0 remain=0
//    ALU_stall|SWM_stall_i: PCW=0 flushes=0 remain=1
//    sb_hit: PCW=0 ID_Flush=1 (bubble) remain=1
//    else: PCW=1 flushes=0 remain=0
//  - issue = advance && !ID_Flush && id_wr_en && id_wr_reg!=0.
//  - Per advance cycle, each cnt[r]!=0 decrements by 1. On issue,
//    cnt[id_wr_reg] <= id_wr_lat, overriding the decrement (WAW: newest wins).
//    ex_vld<=issue, ex_reg<=id_wr_reg.
//  - Squash: on PCSrc (EX_Flush), if ex_vld, cnt[ex_reg]<=0 (killed producer
//    never writes). The squash beats that register's decrement. No issue occurs
//    that cycle, since ID is flushed.
//  - Register 0 is never written or checked. Latency 0 issues set no busy entry.
//  - Non-advance cycles: all state holds (ex_vld unchanged).
//  - Reset mid-stall: clears immediately. The next cycle sees no hit.
// CONFIGURATION
//  HAZ_STATS_EN defined: adds outputs stall_cyc (32b) and flush_cnt (16b).
//    stall_cyc increments on cycles with PCWrite=0. flush_cnt increments on
//    each IF_Flush. Both saturate, reset to 0, and are cleared by input stats_clr_i.
//  Not defined: ports, counters and stats_clr_i are absent. Behaviour is otherwise identical.
// TESTING
//  - Reset release, idle inputs -> PCWrite=1, all flushes 0, remain=0, sb_busy=0.
//  - Issue wr r5 lat=1, next ID src r5 -> 1 cycle PCW=0 ID_Flush=1 remain=1, then proceeds.
//  - Issue wr r7 lat=3, ALU_stall high 2 cycles mid-countdown -> stall lasts 3 advance cycles (5 clocks total).
//  - Issue wr r9 lat=4 then PCSrc next cycle -> all flushes 1; cnt[r9]=0; following r9 reader has no stall.
//  - r3 lat=3 then r3 lat=0 (WAW), reader of r3 -> no stall. Reader of r0 with busy state -> no stall.
//  - EX_j with sb_hit and ALU_stall both high -> jump row wins: PCW=1 IF/ID_Flush=1 remain=0.

Source files
------------

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if
//   Bundles the hazard/scoreboard control signals between the ID-stage
//   pipeline logic (master) and the hazard scoreboard unit (slave).
//   Signals:
//     PCSrc, EX_j, EX_jal, EX_jr    EX-stage redirect indications
//     ALU_stall, SWM_stall_i        structural stalls
//     id_src_vld/id_src_reg         ID source operands (packed)
//     id_wr_en/id_wr_reg/id_wr_lat  ID destination and producer latency
//     PCWrite, IF_ID_remain         PC / IF-ID hold controls
//     IF_Flush, ID_Flush, EX_Flush  stage flushes
//     sb_busy                       any scoreboard entry pending
//   Optional (HAZ_STATS_EN): stats_clr_i, stall_cyc, flush_cnt.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 3
);
  logic                      PCSrc;
  logic                      EX_j;
  logic                      EX_jal;
  logic                      EX_jr;
  logic                      ALU_stall;
  logic                      SWM_stall_i;
  logic [NUM_SRC-1:0]        id_src_vld;
  logic [NUM_SRC*REG_AW-1:0] id_src_reg;
  logic                      id_wr_en;
  logic [REG_AW-1:0]         id_wr_reg;
  logic [CNT_W-1:0]          id_wr_lat;
  logic                      PCWrite;
  logic                      IF_ID_remain;
  logic                      IF_Flush;
  logic                      ID_Flush;
  logic                      EX_Flush;
  logic                      sb_busy;
`ifdef HAZ_STATS_EN
  logic                      stats_clr_i;
  logic [31:0]               stall_cyc;
  logic [15:0]               flush_cnt;
`endif

  modport master (
    output PCSrc, EX_j, EX_jal, EX_jr, ALU_stall, SWM_stall_i,
    output id_src_vld, id_src_reg, id_wr_en, id_wr_reg, id_wr_lat,
`ifdef HAZ_STATS_EN
    output stats_clr_i,
    input  stall_cyc, flush_cnt,
`endif
    input  PCWrite, IF_ID_remain, IF_Flush, ID_Flush, EX_Flush, sb_busy
  );

  modport slave (
    input  PCSrc, EX_j, EX_jal, EX_jr, ALU_stall, SWM_stall_i,
    input  id_src_vld, id_src_reg, id_wr_en, id_wr_reg, id_wr_lat,
`ifdef HAZ_STATS_EN
    input  stats_clr_i,
    output stall_cyc, flush_cnt,
`endif
    output PCWrite, IF_ID_remain, IF_Flush, ID_Flush, EX_Flush, sb_busy
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Per-register scoreboard of result-ready countdowns beside the ID stage.
//   Stalls ID (bubble) until every read source is forwardable, for producers
//   of any latency, and drives PC/IF-ID/flush controls with priority
//   branch > jump > ALU stall > SWM stall > scoreboard stall.
//   Ports:
//     clk_i  rising-edge clock
//     rst_n  asynchronous active-low reset
//     hz     hazard_scoreboard_unit_if.slave (see interface for signals)
//   Optional feature macro HAZ_STATS_EN: saturating stall-cycle and flush
//   counters with synchronous clear via stats_clr_i.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  hazard_scoreboard_unit_if.slave   hz
);
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic              ex_vld_q, ex_vld_d;
  logic [REG_AW-1:0] ex_reg_q, ex_reg_d;

  logic advance;
  logic sb_hit;
  logic busy;
  logic issue;
  logic pcw, remain, if_fl, id_fl, ex_fl;

  assign advance = !hz.ALU_stall && !hz.SWM_stall_i;

  always_comb begin
    sb_hit = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (hz.id_src_vld[s] && (hz.id_src_reg[s*REG_AW +: REG_AW] != '0) &&
          (cnt_q[hz.id_src_reg[s*REG_AW +: REG_AW]] != '0))
        sb_hit = 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      if (cnt_q[r] != '0) busy = 1'b1;
  end

  always_comb begin
    pcw    = 1'b1;
    remain = 1'b0;
    if_fl  = 1'b0;
    id_fl  = 1'b0;
    ex_fl  = 1'b0;
    if (hz.PCSrc) begin
      if_fl = 1'b1;
      id_fl = 1'b1;
      ex_fl = 1'b1;
    end else if (hz.EX_jr || hz.EX_j || hz.EX_jal) begin
      if_fl = 1'b1;
      id_fl = 1'b1;
    end else if (hz.ALU_stall || hz.SWM_stall_i) begin
      pcw    = 1'b0;
      remain = 1'b1;
    end else if (sb_hit) begin
      pcw    = 1'b0;
      remain = 1'b1;
      id_fl  = 1'b1;
    end
  end

  assign hz.PCWrite      = pcw;
  assign hz.IF_ID_remain = remain;
  assign hz.IF_Flush     = if_fl;
  assign hz.ID_Flush     = id_fl;
  assign hz.EX_Flush     = ex_fl;
  assign hz.sb_busy      = busy;

  assign issue = advance && !id_fl && hz.id_wr_en && (hz.id_wr_reg != '0);

  // Order inside an advance cycle: decrement, then squash of the killed EX
  // producer, then the new issue (squash and issue are mutually exclusive
  // because a squash always flushes ID).
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) cnt_d[r] = cnt_q[r];
    ex_vld_d = ex_vld_q;
    ex_reg_d = ex_reg_q;
    if (advance) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_W'(1);
      if (ex_fl && ex_vld_q) cnt_d[ex_reg_q] = '0;
      if (issue) cnt_d[hz.id_wr_reg] = hz.id_wr_lat;
      ex_vld_d = issue;
      ex_reg_d = hz.id_wr_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      ex_vld_q <= 1'b0;
      ex_reg_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      ex_vld_q <= ex_vld_d;
      ex_reg_q <= ex_reg_d;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.stats_clr_i) begin
      stall_cyc_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pcw && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 32'd1;
      if (if_fl && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cyc = stall_cyc_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;
  logic clk;
  logic rst_n;

  hazard_scoreboard_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(3)) hif ();

  hazard_scoreboard_unit #(.REG_AW(5), .NUM_SRC(2), .CNT_W(3)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] v;   // {PCWrite, IF_ID_remain, IF_Flush, ID_Flush, EX_Flush, sb_busy}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // ctl = {PCSrc, EX_j, EX_jal, EX_jr, ALU_stall, SWM_stall_i}
  task automatic drive(input logic [5:0] ctl, input logic [1:0] vld,
                       input logic [4:0] s1, input logic [4:0] s0,
                       input logic wen, input logic [4:0] wreg, input logic [2:0] lat);
    {hif.PCSrc, hif.EX_j, hif.EX_jal, hif.EX_jr, hif.ALU_stall, hif.SWM_stall_i} = ctl;
    hif.id_src_vld = vld;
    hif.id_src_reg = {s1, s0};
    hif.id_wr_en   = wen;
    hif.id_wr_reg  = wreg;
    hif.id_wr_lat  = lat;
  endtask

  task automatic check_out();
    exp_t       e;
    logic [5:0] obs;
    e   = exp_q.pop_front();
    obs = {hif.PCWrite, hif.IF_ID_remain, hif.IF_Flush, hif.ID_Flush, hif.EX_Flush, hif.sb_busy};
    n_cmp++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
  endtask

  // One clock: drive, push expectation, compare at negedge, then cross posedge.
  task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] vld,
                      input logic [4:0] s1, input logic [4:0] s0,
                      input logic wen, input logic [4:0] wreg, input logic [2:0] lat,
                      input logic [5:0] expv);
    exp_t e;
    drive(ctl, vld, s1, s0, wen, wreg, lat);
    e.tag = tag;
    e.v   = expv;
    exp_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef HAZ_STATS_EN
    hif.stats_clr_i = 1'b0;
`endif
    drive(6'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    step("reset_idle", 6'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100000);
    rst_n = 1'b1;
    step("post_reset_idle", 6'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100000);

    // Load-use style: r5 latency 1 -> one bubble
    step("r5_issue",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 3'd1, 6'b100000);
    step("r5_stall",     6'b0, 2'b01, 5'd0, 5'd5, 1'b0, 5'd0, 3'd0, 6'b010101);
    step("r5_proceed",   6'b0, 2'b01, 5'd0, 5'd5, 1'b0, 5'd0, 3'd0, 6'b100000);

    // r7 latency 3, ALU stall freezes countdown for 2 clocks
    step("r7_issue",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 3'd3, 6'b100000);
    step("r7_hit1",      6'b0, 2'b10, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010101);
    step("r7_alu1",      6'b000010, 2'b10, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010001);
    step("r7_alu2",      6'b000010, 2'b10, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010001);
    step("r7_hit2",      6'b0, 2'b10, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010101);
    step("r7_hit3",      6'b0, 2'b10, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010101);
    step("r7_proceed",   6'b0, 2'b10, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100000);

    // r9 latency 4 squashed by a taken branch
    step("r9_issue",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 3'd4, 6'b100000);
    step("r9_branch",    6'b100000, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b101111);
    step("r9_no_stall",  6'b0, 2'b01, 5'd0, 5'd9, 1'b0, 5'd0, 3'd0, 6'b100000);

    // WAW: newest (latency 0) wins
    step("r3_issue_l3",  6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 3'd3, 6'b100000);
    step("r3_issue_l0",  6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 3'd0, 6'b100001);
    step("r3_no_stall",  6'b0, 2'b01, 5'd0, 5'd3, 1'b0, 5'd0, 3'd0, 6'b100000);

    // r0 never checked; unread source never checked
    step("r4_issue",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 3'd3, 6'b100000);
    step("r0_read",      6'b0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100001);
    step("r4_src1_hit",  6'b0, 2'b10, 5'd4, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010101);
    step("r4_unread",    6'b0, 2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100001);
    step("r4_drained",   6'b0, 2'b10, 5'd4, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100000);
    step("r0_write",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 3'd7, 6'b100000);
    step("r0_no_busy",   6'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b100000);

    // Priority: jump beats ALU stall and scoreboard hit
    step("r6_issue",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd6, 3'd2, 6'b100000);
    step("j_over_stall", 6'b010010, 2'b01, 5'd0, 5'd6, 1'b0, 5'd0, 3'd0, 6'b101101);
    step("r6_hit_held",  6'b0, 2'b01, 5'd0, 5'd6, 1'b0, 5'd0, 3'd0, 6'b010101);
    step("jr_row",       6'b000100, 2'b00, 5'd0, 5'd0, 1'b1, 5'd6, 3'd5, 6'b101101);
    step("jal_row",      6'b001000, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b101100);
    step("swm_row",      6'b000001, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b010000);
    step("branch_over_j",6'b110010, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 6'b101110);

    // Async reset in the middle of a stall
    step("r8_issue",     6'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd8, 3'd5, 6'b100000);
    step("r8_stall",     6'b0, 2'b01, 5'd0, 5'd8, 1'b0, 5'd0, 3'd0, 6'b010101);
    drive(6'b0, 2'b01, 5'd0, 5'd8, 1'b0, 5'd0, 3'd0);
    #2 rst_n = 1'b0;
    exp_q.push_back('{tag: "reset_mid_stall", v: 6'b100000});
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("after_reset",  6'b0, 2'b01, 5'd0, 5'd8, 1'b0, 5'd0, 3'd0, 6'b100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
